// File: rtl/ttt_tick_sequencer.sv
// Tick/host instruction sequencer in front of one ttt_processor.
// Optional TTT_SEQ_EVENT_FIFO_EN: 4-entry event FIFO with evt_ready backpressure.
module ttt_tick_sequencer #(
    parameter int TICK_DIV_BITS = 16,
    parameter int OVF_BITS      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic [TICK_DIV_BITS-1:0] tick_period,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic [3:0]               host_instr,
    input  logic [7:0]               host_data,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_data,
    output logic                     proc_en,
    output logic [3:0]               proc_instr,
    output logic [7:0]               proc_data,
    input  logic [7:0]               proc_data_out,
    input  logic                     proc_token_start,
    input  logic                     proc_token_stop,
    output logic                     evt_valid,
    output logic                     evt_start,
    output logic                     evt_stop,
`ifdef TTT_SEQ_EVENT_FIFO_EN
    input  logic                     evt_ready,
`endif
    output logic [OVF_BITS-1:0]      overrun_cnt
);

    typedef enum logic [2:0] {
        IDLE, H_ISSUE, H_CAP, T_ISSUE, T_CAP, C_ISSUE, C_CAP
    } state_e;

    state_e                   state_q, state_d;
    logic [TICK_DIV_BITS-1:0] cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic [OVF_BITS-1:0]      ovf_q, ovf_d;
    logic [3:0]               hinstr_q, hinstr_d;
    logic [7:0]               hdata_q, hdata_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [7:0]               rsp_data_q, rsp_data_d;
    logic                     tstart_q, tstart_d;
    logic                     tstop_q, tstop_d;

    logic tick;
    logic tick_go;
    logic host_acc;
    logic fifo_full;
    logic ev_push;
    logic ev_start;
    logic ev_stop;

    assign tick     = run && (cnt_q == tick_period);
    // A full event FIFO parks the tick but must not block host traffic
    assign tick_go  = (state_q == IDLE) && pend_q && !fifo_full;
    assign host_acc = host_valid && host_ready;
    assign ev_push  = (state_q == C_CAP);
    assign ev_start = tstart_q;
    assign ev_stop  = tstop_q | proc_token_stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            ovf_q       <= '0;
            hinstr_q    <= '0;
            hdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            tstart_q    <= 1'b0;
            tstop_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            hinstr_q    <= hinstr_d;
            hdata_q     <= hdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tstart_q    <= tstart_d;
            tstop_q     <= tstop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tick_go)         state_d = T_ISSUE;
                else if (host_valid) state_d = H_ISSUE;
            end
            H_ISSUE: state_d = H_CAP;
            H_CAP:   state_d = IDLE;
            T_ISSUE: state_d = T_CAP;
            T_CAP:   state_d = C_ISSUE;
            C_ISSUE: state_d = C_CAP;
            C_CAP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        hinstr_d    = hinstr_q;
        hdata_d     = hdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        tstart_d    = tstart_q;
        tstop_d     = tstop_q;
        if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        // T_ISSUE consumes the pending tick; a coincident tick re-arms it
        if (state_q == T_ISSUE) begin
            pend_d = tick;
        end else if (tick) begin
            pend_d = 1'b1;
            if (pend_q && (ovf_q != '1)) begin
                ovf_d = ovf_q + 1'b1;
            end
        end
        if (host_acc) begin
            hinstr_d = host_instr;
            hdata_d  = host_data;
        end
        if (state_q == H_CAP) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = proc_data_out;
        end
        if (state_q == T_CAP) begin
            tstart_d = proc_token_start;
            tstop_d  = proc_token_stop;
        end
    end

    always_comb begin
        host_ready = rst_n && (state_q == IDLE) && !(pend_q && !fifo_full);
        proc_en    = 1'b0;
        proc_instr = 4'b0000;
        proc_data  = 8'h00;
        unique case (state_q)
            H_ISSUE: begin
                proc_en    = 1'b1;
                proc_instr = hinstr_q;
                proc_data  = hdata_q;
            end
            T_ISSUE: begin
                proc_en    = 1'b1;
                proc_instr = 4'b1000;
            end
            C_ISSUE: begin
                proc_en    = 1'b1;
                proc_instr = 4'b1001;
            end
            default: ;
        endcase
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign overrun_cnt = ovf_q;

`ifdef TTT_SEQ_EVENT_FIFO_EN
    logic [1:0] fifo_q [4];
    logic [1:0] fifo_d [4];
    logic [1:0] wr_q, wr_d;
    logic [1:0] rd_q, rd_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic       pop;
    logic       push;

    assign fifo_full = (fcnt_q == 3'd4);
    assign evt_valid = (fcnt_q != 3'd0);
    assign pop       = evt_valid && evt_ready;
    assign push      = ev_push && (!fifo_full || pop);
    assign evt_start = evt_valid && fifo_q[rd_q][1];
    assign evt_stop  = evt_valid && fifo_q[rd_q][0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 2'b00;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= fifo_d[i];
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) fifo_d[i] = fifo_q[i];
        wr_d   = wr_q;
        rd_d   = rd_q;
        fcnt_d = fcnt_q + {2'b00, push} - {2'b00, pop};
        if (push) begin
            fifo_d[wr_q] = {ev_start, ev_stop};
            wr_d         = wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = rd_q + 2'd1;
        end
    end
`else
    logic evt_valid_q, evt_valid_d;
    logic evt_start_q, evt_start_d;
    logic evt_stop_q, evt_stop_d;

    assign fifo_full = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_valid_q <= 1'b0;
            evt_start_q <= 1'b0;
            evt_stop_q  <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_start_q <= evt_start_d;
            evt_stop_q  <= evt_stop_d;
        end
    end

    always_comb begin
        evt_valid_d = ev_push;
        evt_start_d = ev_push && ev_start;
        evt_stop_d  = ev_push && ev_stop;
    end

    assign evt_valid = evt_valid_q;
    assign evt_start = evt_start_q;
    assign evt_stop  = evt_stop_q;
`endif

endmodule

// File: tb/tb_ttt_tick_sequencer.sv
// Scoreboard bench for ttt_tick_sequencer with a small processor model.
// Define TTT_SEQ_EVENT_FIFO_EN to also exercise the event FIFO.
module tb_ttt_tick_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] tick_period = '0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [3:0]  host_instr = '0;
    logic [7:0]  host_data = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        proc_en;
    logic [3:0]  proc_instr;
    logic [7:0]  proc_data;
    logic [7:0]  m_do = '0;
    logic        m_start = 1'b0;
    logic        m_stop = 1'b0;
    logic        evt_valid;
    logic        evt_start;
    logic        evt_stop;
    logic        evt_ready = 1'b1;
    logic [7:0]  overrun_cnt;

    logic cfg_start = 1'b0;
    logic cfg_stop_t = 1'b0;
    logic cfg_stop_c = 1'b0;
    logic chk_per = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_tally = 0;
    int prev_tally = 0;
    bit have_prev = 0;

    logic [7:0] rsp_q [$];
    int         acc_q [$];
    logic [1:0] evt_q [$];

    ttt_tick_sequencer #(.TICK_DIV_BITS(16), .OVF_BITS(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .tick_period(tick_period),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_instr(host_instr),
        .host_data(host_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .proc_en(proc_en),
        .proc_instr(proc_instr),
        .proc_data(proc_data),
        .proc_data_out(m_do),
        .proc_token_start(m_start),
        .proc_token_stop(m_stop),
        .evt_valid(evt_valid),
        .evt_start(evt_start),
        .evt_stop(evt_stop),
`ifdef TTT_SEQ_EVENT_FIFO_EN
        .evt_ready(evt_ready),
`endif
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pfn(input logic [3:0] i, input logic [7:0] d);
        return d ^ {i, ~i};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) @cyc %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Processor model: results valid one cycle after issue
    always @(posedge clk) begin
        if (proc_en) begin
            m_do    <= pfn(proc_instr, proc_data);
            m_start <= (proc_instr == 4'b1000) && cfg_start;
            m_stop  <= (proc_instr == 4'b1000) ? cfg_stop_t :
                       (proc_instr == 4'b1001) ? cfg_stop_c : 1'b0;
        end
    end

    // Monitor: pushes expectations on stimulus, pops on DUT output
    always @(negedge clk) begin
        if (rst_n) begin
            if (host_valid && host_ready) begin
                rsp_q.push_back(pfn(host_instr, host_data));
                acc_q.push_back(cyc);
            end
            if (proc_en && proc_instr == 4'b1000 && proc_data == 8'h00) begin
                n_tally++;
                evt_q.push_back({cfg_start, cfg_stop_t | cfg_stop_c});
                if (chk_per && have_prev) check("tick_interval", cyc - prev_tally, 10);
                prev_tally = cyc;
                have_prev  = 1;
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_data", rsp_data, rsp_q.pop_front());
                    check("rsp_latency", cyc - acc_q.pop_front(), 3);
                end
            end
`ifdef TTT_SEQ_EVENT_FIFO_EN
            if (evt_valid && evt_ready) begin
`else
            if (evt_valid) begin
`endif
                if (evt_q.size() == 0) check("evt_unexpected", 1, 0);
                else check("evt_flags", {evt_start, evt_stop}, evt_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        check("rst_host_ready", host_ready, 0);
        check("rst_proc_en", proc_en, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ovf", overrun_cnt, 0);
        check("rst_proc_instr", proc_instr, 0);
        rsp_q.delete();
        acc_q.delete();
        evt_q.delete();
        have_prev = 0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        run = 1'b0;
        host_valid = 1'b0;
        step(n);
        check("rsp_q_empty", rsp_q.size(), 0);
        check("evt_q_empty", evt_q.size(), 0);
    endtask

    task automatic host_txn(input logic [3:0] i, input logic [7:0] d, output int acc);
        host_valid = 1'b1;
        host_instr = i;
        host_data  = d;
        acc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (host_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("host_accept_timeout", 0, 1);
        step(1);
        host_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, c0, base, found;
        do_reset();

        // Single host instruction: issue next cycle, response after 3
        host_txn(4'b0011, 8'h16, acc);
        @(negedge clk);
        check("h_proc_en", proc_en, 1);
        check("h_proc_instr", proc_instr, 4'b0011);
        check("h_proc_data", proc_data, 8'h16);
        step(4);
        check("h_0x2a_expect", pfn(4'b0011, 8'h16), 8'h2A);

        // Host batch including tally/countdown codes
        host_txn(4'b1000, 8'h55, acc);
        host_txn(4'b1001, 8'hA0, acc);
        for (int k = 0; k < 6; k++) begin
            host_txn(4'($urandom_range(0, 15)), 8'($urandom_range(1, 255)), acc);
        end
        drain(6);

        // Periodic ticks, start on tally, stop on countdown
        cfg_start = 1'b1; cfg_stop_t = 1'b0; cfg_stop_c = 1'b1;
        tick_period = 16'd9;
        chk_per = 1'b1;
        base = n_tally;
        run = 1'b1;
        step(45);
        check("tick_count", (n_tally - base) >= 4, 1);
        chk_per = 1'b0;
        drain(10);

        cfg_start = 1'b0; cfg_stop_t = 1'b1; cfg_stop_c = 1'b0;
        run = 1'b1;
        step(25);
        drain(10);

        // Pending tick beats a held host request
        do_reset();
        cfg_start = 1'b1; cfg_stop_t = 1'b1; cfg_stop_c = 1'b0;
        tick_period = 16'd0;
        run = 1'b1;
        step(1);
        run = 1'b0;
        host_valid = 1'b1; host_instr = 4'b0110; host_data = 8'h77;
        @(negedge clk);
        c0 = cyc;
        check("prio_ready_low", host_ready, 0);
        @(negedge clk);
        check("prio_tally_first", {proc_en, proc_instr}, 5'b1_1000);
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (host_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("prio_host_after_pair", acc - c0, 5);
        step(1);
        drain(8);

        // Exact overrun count with a tick every cycle
        do_reset();
        cfg_start = 1'b0; cfg_stop_t = 1'b0; cfg_stop_c = 1'b0;
        tick_period = 16'd0;
        run = 1'b1;
        step(7);
        run = 1'b0;
        @(negedge clk);
        check("ovf_exact", overrun_cnt, 5);
        drain(15);

        // Saturation under continuous host traffic
        run = 1'b1;
        host_valid = 1'b1; host_instr = 4'b0101; host_data = 8'h33;
        step(400);
        check("ovf_sat", overrun_cnt, 255);
        step(40);
        check("ovf_hold", overrun_cnt, 255);
        drain(15);

        // Reset in T_CAP aborts the pair, then ticks resume
        do_reset();
        tick_period = 16'd4;
        run = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (proc_en && proc_instr == 4'b1000) begin
                found = 1;
                break;
            end
        end
        check("tcap_tally_seen", found, 1);
        step(1);
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        check("tcap_rst_proc_en", proc_en, 0);
        check("tcap_rst_evt", {evt_valid, evt_start, evt_stop}, 0);
        check("tcap_rst_rsp", rsp_valid, 0);
        check("tcap_rst_ready", host_ready, 0);
        evt_q.delete();
        have_prev = 0;
        base = n_tally;
        step(1);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (n_tally != base) break;
        end
        check("tcap_tick_resume", n_tally - base, 1);
        drain(10);

`ifdef TTT_SEQ_EVENT_FIFO_EN
        // Full FIFO parks ticks; draining releases the pending one
        do_reset();
        evt_ready = 1'b0;
        cfg_start = 1'b1; cfg_stop_t = 1'b0; cfg_stop_c = 1'b1;
        tick_period = 16'd9;
        base = n_tally;
        run = 1'b1;
        step(65);
        run = 1'b0;
        @(negedge clk);
        check("fifo_tallies_full", n_tally - base, 4);
        check("fifo_evt_valid", evt_valid, 1);
        host_txn(4'b0010, 8'h44, acc);
        check("fifo_host_served", acc >= 0, 1);
        step(1);
        evt_ready = 1'b1;
        step(30);
        check("fifo_pending_ran", n_tally - base, 5);
        drain(10);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
